// File: rtl/ni_flit_injector.sv
// NI injection stage: turns packet requests plus a body stream into flits on one VC,
// gated by per-VC downstream credits so the router local input buffer never overflows.
module ni_flit_injector #(
    parameter int unsigned V            = 4,
    parameter int unsigned B            = 4,
    parameter int unsigned Fpay         = 32,
    parameter int unsigned MIN_PCK_SIZE = 2,
    parameter int unsigned PCK_SIZEw    = 8,
    localparam int unsigned Fw          = 2 + V + Fpay
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pck_valid,
    output logic                 pck_ready,
    input  logic [V-1:0]         pck_vc,
    input  logic [PCK_SIZEw-1:0] pck_size,
    input  logic [Fpay-1:0]      pck_hdr,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic [Fpay-1:0]      data_in,
    output logic [Fw-1:0]        flit_out,
    output logic                 flit_out_we,
    input  logic [V-1:0]         credit_in,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(B + 1);
    localparam logic [CW-1:0] CreditMax = CW'(B);
    localparam logic [PCK_SIZEw-1:0] MinSize = PCK_SIZEw'(MIN_PCK_SIZE);

    typedef enum logic [1:0] {StIdle, StHead, StBody} state_e;

    state_e                   state_q, state_d;
    logic [V-1:0]             vc_q, vc_d;
    logic [PCK_SIZEw-1:0]     remain_q, remain_d;
    logic [Fpay-1:0]          hdr_q, hdr_d;
    logic [V-1:0][CW-1:0]     credit_q, credit_d;
    logic [Fw-1:0]            flit_q, flit_d;
    logic                     flit_we_q;

    logic                     issue;
    logic [PCK_SIZEw-1:0]     eff_size;
    logic [V-1:0]             has_credit;
    logic                     vc_has_credit;
    logic                     last_flit;

    // Zero-length requests are illegal; they fall into the minimum-size clamp.
    assign eff_size = (pck_size < MinSize) ? MinSize : pck_size;

    always_comb begin
        for (int v = 0; v < V; v++) begin
            has_credit[v] = (credit_q[v] != '0);
        end
    end

    assign vc_has_credit = |(has_credit & vc_q);
    assign last_flit     = (remain_q == PCK_SIZEw'(1));

    always_comb begin
        state_d    = state_q;
        vc_d       = vc_q;
        remain_d   = remain_q;
        hdr_d      = hdr_q;
        issue      = 1'b0;
        flit_d     = '0;
        pck_ready  = 1'b0;
        data_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                pck_ready = 1'b1;
                if (pck_valid) begin
                    vc_d     = pck_vc;
                    hdr_d    = pck_hdr;
                    remain_d = eff_size;
                    state_d  = StHead;
                end
            end
            StHead: begin
                // remain_q holds the full packet length until the header goes out.
                if (vc_has_credit) begin
                    issue    = 1'b1;
                    flit_d   = {1'b1, last_flit, vc_q, hdr_q};
                    remain_d = remain_q - PCK_SIZEw'(1);
                    state_d  = last_flit ? StIdle : StBody;
                end
            end
            StBody: begin
                data_ready = vc_has_credit;
                if (data_valid && vc_has_credit) begin
                    issue    = 1'b1;
                    flit_d   = {1'b0, last_flit, vc_q, data_in};
                    remain_d = remain_q - PCK_SIZEw'(1);
                    if (last_flit) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A simultaneous issue and return cancel; returns beyond B are dropped.
    always_comb begin
        credit_d = credit_q;
        for (int v = 0; v < V; v++) begin
            if (issue && vc_q[v] && !credit_in[v]) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end else if (credit_in[v] && !(issue && vc_q[v]) && credit_q[v] != CreditMax) begin
                credit_d[v] = credit_q[v] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            vc_q      <= '0;
            remain_q  <= '0;
            hdr_q     <= '0;
            flit_q    <= '0;
            flit_we_q <= 1'b0;
            for (int v = 0; v < V; v++) begin
                credit_q[v] <= CreditMax;
            end
        end else begin
            state_q   <= state_d;
            vc_q      <= vc_d;
            remain_q  <= remain_d;
            hdr_q     <= hdr_d;
            flit_q    <= flit_d;
            flit_we_q <= issue;
            credit_q  <= credit_d;
        end
    end

    assign flit_out    = flit_q;
    assign flit_out_we = flit_we_q;
    assign busy        = (state_q != StIdle);

    // Protocol checks: credit overflow and non-one-hot VC at acceptance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int v = 0; v < V; v++) begin
                assert (!(credit_in[v] && credit_q[v] == CreditMax))
                else $warning("ni_flit_injector: credit return on VC %0d already holding B", v);
            end
            if (state_q == StIdle && pck_valid) begin
                assert ($onehot(pck_vc))
                else $warning("ni_flit_injector: pck_vc %b is not one-hot", pck_vc);
            end
        end
    end

endmodule

// File: tb/tb_ni_flit_injector.sv
// Directed bench for ni_flit_injector: flit sequencing, credit accounting, size clamp,
// mid-packet reset and back-to-back packets.
module tb_ni_flit_injector;

    localparam int unsigned V = 4;
    localparam int unsigned Fpay = 32;
    localparam int unsigned Fw = 2 + V + Fpay;

    logic            clk = 1'b0;
    logic            reset;
    logic            pck_valid;
    logic            pck_ready;
    logic [V-1:0]    pck_vc;
    logic [7:0]      pck_size;
    logic [Fpay-1:0] pck_hdr;
    logic            data_valid;
    logic            data_ready;
    logic [Fpay-1:0] data_in;
    logic [Fw-1:0]   flit_out;
    logic            flit_out_we;
    logic [V-1:0]    credit_in;
    logic            busy;

    int n_pass = 0;
    int n_total = 0;

    ni_flit_injector #(
        .V(4), .B(4), .Fpay(32), .MIN_PCK_SIZE(2), .PCK_SIZEw(8)
    ) dut (
        .clk(clk), .reset(reset),
        .pck_valid(pck_valid), .pck_ready(pck_ready), .pck_vc(pck_vc),
        .pck_size(pck_size), .pck_hdr(pck_hdr),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .flit_out(flit_out), .flit_out_we(flit_out_we),
        .credit_in(credit_in), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] mk(input logic h, input logic t, input logic [3:0] vc,
                                       input logic [31:0] p);
        return {26'd0, h, t, vc, p};
    endfunction

    task automatic chk_credit(input string tag, input int v, input int exp);
        chk(tag, 64'(dut.credit_q[v]), 64'(exp));
    endtask

    initial begin
        reset = 1'b1; pck_valid = 1'b0; pck_vc = '0; pck_size = '0; pck_hdr = '0;
        data_valid = 1'b0; data_in = '0; credit_in = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_we", 64'(flit_out_we), 64'd0);
        chk("rst_flit", 64'(flit_out), 64'd0);
        chk("rst_pck_ready", 64'(pck_ready), 64'd1);
        chk("rst_data_ready", 64'(data_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        for (int v = 0; v < 4; v++) chk_credit("rst_credit", v, 4);

        // 1: three-flit packet on VC0
        pck_valid = 1'b1; pck_vc = 4'b0001; pck_size = 8'd3; pck_hdr = 32'hA5;
        data_valid = 1'b1; data_in = 32'h11;
        tick();
        pck_valid = 1'b0;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_no_flit_at_accept", 64'(flit_out_we), 64'd0);
        chk("t1_pck_ready_low", 64'(pck_ready), 64'd0);
        tick();
        chk("t1_we_hdr", 64'(flit_out_we), 64'd1);
        chk("t1_hdr", 64'(flit_out), mk(1'b1, 1'b0, 4'b0001, 32'hA5));
        tick();
        chk("t1_body", 64'(flit_out), mk(1'b0, 1'b0, 4'b0001, 32'h11));
        data_in = 32'h22;
        tick();
        chk("t1_tail", 64'(flit_out), mk(1'b0, 1'b1, 4'b0001, 32'h22));
        chk("t1_idle", 64'(busy), 64'd0);
        tick();
        chk("t1_we_off", 64'(flit_out_we), 64'd0);
        chk_credit("t1_credit0", 0, 1);

        // 2: six-flit packet on VC1 with credits withheld
        pck_valid = 1'b1; pck_vc = 4'b0010; pck_size = 8'd6; pck_hdr = 32'hB6;
        tick();
        pck_valid = 1'b0;
        tick();
        chk("t2_hdr", 64'(flit_out), mk(1'b1, 1'b0, 4'b0010, 32'hB6));
        for (int i = 1; i <= 3; i++) begin
            data_in = 32'h200 + 32'(i);
            tick();
            chk("t2_body", 64'(flit_out), mk(1'b0, 1'b0, 4'b0010, 32'h200 + 32'(i)));
        end
        data_in = 32'h204;
        tick();
        chk("t2_stall_we", 64'(flit_out_we), 64'd0);
        chk("t2_stall_ready", 64'(data_ready), 64'd0);
        chk_credit("t2_credit1_zero", 1, 0);
        tick();
        chk("t2_stall_we2", 64'(flit_out_we), 64'd0);
        credit_in = 4'b0010;
        tick();
        credit_in = '0;
        chk("t2_ready_after_credit", 64'(data_ready), 64'd1);
        tick();
        chk("t2_one_more", 64'(flit_out), mk(1'b1 ^ 1'b1, 1'b0, 4'b0010, 32'h204));
        chk("t2_one_more_we", 64'(flit_out_we), 64'd1);
        data_in = 32'h205;
        tick();
        chk("t2_only_one_we", 64'(flit_out_we), 64'd0);
        chk("t2_only_one_ready", 64'(data_ready), 64'd0);
        credit_in = 4'b0010;
        tick();
        credit_in = '0;
        tick();
        chk("t2_tail", 64'(flit_out), mk(1'b0, 1'b1, 4'b0010, 32'h205));
        chk("t2_idle", 64'(busy), 64'd0);

        // 3: size 0 and size 1 both become two-flit packets
        pck_valid = 1'b1; pck_vc = 4'b0100; pck_size = 8'd0; pck_hdr = 32'hC0;
        data_in = 32'h300;
        tick();
        pck_valid = 1'b0;
        tick();
        chk("t3_s0_hdr", 64'(flit_out), mk(1'b1, 1'b0, 4'b0100, 32'hC0));
        tick();
        chk("t3_s0_tail", 64'(flit_out), mk(1'b0, 1'b1, 4'b0100, 32'h300));
        tick();
        chk("t3_s0_done_we", 64'(flit_out_we), 64'd0);
        chk("t3_s0_done_ready", 64'(pck_ready), 64'd1);
        pck_valid = 1'b1; pck_vc = 4'b1000; pck_size = 8'd1; pck_hdr = 32'hC1;
        data_in = 32'h301;
        tick();
        pck_valid = 1'b0;
        tick();
        chk("t3_s1_hdr", 64'(flit_out), mk(1'b1, 1'b0, 4'b1000, 32'hC1));
        tick();
        chk("t3_s1_tail", 64'(flit_out), mk(1'b0, 1'b1, 4'b1000, 32'h301));
        tick();
        chk("t3_s1_done_we", 64'(flit_out_we), 64'd0);

        // 4: issue and return on VC2 in the same cycle; overflow on idle VC3
        pck_valid = 1'b1; pck_vc = 4'b0100; pck_size = 8'd2; pck_hdr = 32'hC2;
        data_in = 32'h400;
        tick();
        pck_valid = 1'b0;
        credit_in = 4'b0100;
        tick();
        credit_in = '0;
        chk("t4_hdr", 64'(flit_out), mk(1'b1, 1'b0, 4'b0100, 32'hC2));
        chk_credit("t4_credit2_same", 2, 2);
        tick();
        chk("t4_tail", 64'(flit_out), mk(1'b0, 1'b1, 4'b0100, 32'h400));
        chk_credit("t4_credit2_dec", 2, 1);
        data_valid = 1'b0;
        credit_in = 4'b1000;
        tick(); tick();
        chk_credit("t4_credit3_full", 3, 4);
        tick();
        credit_in = '0;
        chk_credit("t4_credit3_hold", 3, 4);

        // 5: reset after two flits of a five-flit packet
        pck_valid = 1'b1; pck_vc = 4'b1000; pck_size = 8'd5; pck_hdr = 32'hD0;
        data_valid = 1'b1; data_in = 32'h501;
        tick();
        pck_valid = 1'b0;
        tick();
        chk("t5_hdr", 64'(flit_out), mk(1'b1, 1'b0, 4'b1000, 32'hD0));
        tick();
        chk("t5_body", 64'(flit_out), mk(1'b0, 1'b0, 4'b1000, 32'h501));
        reset = 1'b1;
        tick();
        chk("t5_we", 64'(flit_out_we), 64'd0);
        chk("t5_flit", 64'(flit_out), 64'd0);
        chk("t5_pck_ready", 64'(pck_ready), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        for (int v = 0; v < 4; v++) chk_credit("t5_credit", v, 4);
        reset = 1'b0;
        tick();
        chk("t5_no_tail", 64'(flit_out_we), 64'd0);

        // 6: back-to-back two-flit packets on VC0 then VC1
        pck_valid = 1'b1; pck_vc = 4'b0001; pck_size = 8'd2; pck_hdr = 32'hE0;
        data_in = 32'h600;
        tick();
        pck_vc = 4'b0010; pck_hdr = 32'hE1;
        tick();
        chk("t6_hdr0", 64'(flit_out), mk(1'b1, 1'b0, 4'b0001, 32'hE0));
        tick();
        chk("t6_tail0", 64'(flit_out), mk(1'b0, 1'b1, 4'b0001, 32'h600));
        chk("t6_ready_again", 64'(pck_ready), 64'd1);
        data_in = 32'h601;
        tick();
        pck_valid = 1'b0;
        chk("t6_bubble", 64'(flit_out_we), 64'd0);
        tick();
        chk("t6_hdr1", 64'(flit_out), mk(1'b1, 1'b0, 4'b0010, 32'hE1));
        tick();
        chk("t6_tail1", 64'(flit_out), mk(1'b0, 1'b1, 4'b0010, 32'h601));
        data_valid = 1'b0;
        tick();
        chk("t6_end_we", 64'(flit_out_we), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
